// File: rtl/round_referee.sv
// Round referee: after a grace period, probes the ball's centre and four edge points
// against the safe-zone map once per frame and decides win/lose for the round.
module round_referee #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_RADIUS   = 10,
  parameter int GRACE_FRAMES  = 30,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT),
  localparam int GW = $clog2(GRACE_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_frame_tick,
  input  logic          i_game_running,
  input  logic          i_regenerate_level,
  input  logic          i_level_rdy,
  input  logic [XW-1:0] i_ball_x,
  input  logic [YW-1:0] i_ball_y,
  output logic          o_query_valid,
  output logic [XW-1:0] o_query_x,
  output logic [YW-1:0] o_query_y,
  input  logic          i_query_safe,
  output logic          o_round_ended,
  output logic          o_is_win,
  output logic          o_busy,
  output logic [2:0]    o_state
);

  // Query handshake: o_query_valid/o_query_x/o_query_y form a request with no
  // back-pressure; i_query_safe answers it exactly one cycle later.
  typedef enum logic [2:0] {
    WAIT_RDY = 3'd0,
    GRACE    = 3'd1,
    ARMED    = 3'd2,
    PROBE    = 3'd3,
    ENDED    = 3'd4
  } state_t;

  localparam logic [XW:0] R_X   = (XW+1)'(BALL_RADIUS);
  localparam logic [YW:0] R_Y   = (YW+1)'(BALL_RADIUS);
  localparam logic [XW:0] X_MAX = (XW+1)'(SCREEN_WIDTH - 1);
  localparam logic [YW:0] Y_MAX = (YW+1)'(SCREEN_HEIGHT - 1);

  state_t        state;
  logic [GW-1:0] grace_cnt;
  logic [2:0]    step;
  logic [XW-1:0] lat_x;
  logic [YW-1:0] lat_y;
  logic          unsafe;

  logic [XW:0]   x_plus_w;
  logic [YW:0]   y_plus_w;
  logic [XW-1:0] x_lo, x_hi, probe_x;
  logic [YW-1:0] y_lo, y_hi, probe_y;
  logic          unsafe_now;
  logic          win_zone;

  // Edge probes clamp to the screen rather than wrapping.
  assign x_plus_w = {1'b0, lat_x} + R_X;
  assign y_plus_w = {1'b0, lat_y} + R_Y;
  assign x_lo     = ({1'b0, lat_x} < R_X) ? '0 : XW'({1'b0, lat_x} - R_X);
  assign y_lo     = ({1'b0, lat_y} < R_Y) ? '0 : YW'({1'b0, lat_y} - R_Y);
  assign x_hi     = (x_plus_w > X_MAX) ? XW'(X_MAX) : XW'(x_plus_w);
  assign y_hi     = (y_plus_w > Y_MAX) ? YW'(Y_MAX) : YW'(y_plus_w);
  assign win_zone = (y_plus_w >= Y_MAX);

  // Responses arrive from step 2 onward; the step-6 response is folded in here.
  assign unsafe_now = unsafe | ((step >= 3'd2) && !i_query_safe);

  always_comb begin
    probe_x = lat_x;
    probe_y = lat_y;
    case (step)
      3'd1:    probe_x = x_lo;
      3'd2:    probe_x = x_hi;
      3'd3:    probe_y = y_lo;
      3'd4:    probe_y = y_hi;
      default: ;
    endcase
  end

  assign o_state = state;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= WAIT_RDY;
      grace_cnt     <= '0;
      step          <= '0;
      lat_x         <= '0;
      lat_y         <= '0;
      unsafe        <= 1'b0;
      o_query_valid <= 1'b0;
      o_query_x     <= '0;
      o_query_y     <= '0;
      o_round_ended <= 1'b0;
      o_is_win      <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_round_ended <= 1'b0;
      o_busy        <= 1'b0;
      if (i_regenerate_level) begin
        state         <= WAIT_RDY;
        o_is_win      <= 1'b0;
        o_query_valid <= 1'b0;
        unsafe        <= 1'b0;
      end else begin
        case (state)
          WAIT_RDY: begin
            if (i_level_rdy) begin
              state     <= GRACE;
              grace_cnt <= GW'(GRACE_FRAMES);
            end
          end
          GRACE: begin
            if (!i_level_rdy) begin
              state <= WAIT_RDY;
            end else if (i_frame_tick && i_game_running) begin
              if (grace_cnt <= GW'(1)) begin
                grace_cnt <= '0;
                state     <= ARMED;
              end else begin
                grace_cnt <= grace_cnt - GW'(1);
              end
            end
          end
          ARMED: begin
            if (!i_level_rdy) begin
              state <= WAIT_RDY;
            end else if (i_frame_tick && i_game_running) begin
              lat_x         <= i_ball_x;
              lat_y         <= i_ball_y;
              unsafe        <= 1'b0;
              step          <= 3'd1;
              o_query_valid <= 1'b1;
              o_query_x     <= i_ball_x;
              o_query_y     <= i_ball_y;
              o_busy        <= 1'b1;
              state         <= PROBE;
            end
          end
          PROBE: begin
            if (!i_level_rdy || !i_game_running) begin
              state         <= i_level_rdy ? ARMED : WAIT_RDY;
              o_query_valid <= 1'b0;
              unsafe        <= 1'b0;
            end else begin
              step   <= step + 3'd1;
              unsafe <= unsafe_now;
              if (step <= 3'd4) begin
                o_query_x <= probe_x;
                o_query_y <= probe_y;
              end else begin
                o_query_valid <= 1'b0;
              end
              if (step == 3'd6) begin
                if (unsafe_now || win_zone) begin
                  o_round_ended <= 1'b1;
                  o_is_win      <= !unsafe_now;
                  state         <= ENDED;
                end else begin
                  state <= ARMED;
                end
              end else begin
                o_busy <= 1'b1;
              end
            end
          end
          ENDED:   ;
          default: state <= WAIT_RDY;
        endcase
      end
    end
  end

endmodule

// File: doc/round_referee.md
ROUND_REFEREE -- requirements
Module: round_referee

Interface
REQ-001 Parameter SCREEN_WIDTH, default 400, screen width in pixels.
REQ-002 Parameter SCREEN_HEIGHT, default 600, screen height in pixels.
REQ-003 Parameter BALL_RADIUS, default 10, probe offset from ball centre in pixels.
REQ-004 Parameter GRACE_FRAMES, default 30, frames ignored after level ready; minimum 1.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_frame_tick  input  1  one-cycle pulse, once per frame.
REQ-008 i_game_running  input  1  level, high while game unpaused.
REQ-009 i_regenerate_level  input  1  pulse, new level requested.
REQ-010 i_level_rdy  input  1  level, safe-zone map valid.
REQ-011 i_ball_x  input  $clog2(SCREEN_WIDTH)  ball centre x.
REQ-012 i_ball_y  input  $clog2(SCREEN_HEIGHT)  ball centre y.
REQ-013 o_query_valid  input-side initiator strobe, output  1  probe request valid.
REQ-014 o_query_x  output  $clog2(SCREEN_WIDTH)  probe x to safe-zone lookup.
REQ-015 o_query_y  output  $clog2(SCREEN_HEIGHT)  probe y to safe-zone lookup.
REQ-016 i_query_safe  input  1  lookup result, valid exactly 1 cycle after o_query_valid.
REQ-017 o_round_ended  output  1  one-cycle pulse, round decided.
REQ-018 o_is_win  output  1  outcome, valid from o_round_ended pulse until next i_regenerate_level.
REQ-019 o_busy  output  1  high in PROBE state.

Function
REQ-020 States: WAIT_RDY, GRACE, ARMED, PROBE, ENDED; all registered.
REQ-021 WAIT_RDY -> GRACE when i_level_rdy high; grace counter loaded with GRACE_FRAMES.
REQ-022 GRACE: counter decrements on i_frame_tick while i_game_running; frozen while paused; -> ARMED on the tick decrementing it to 0.
REQ-023 ARMED: i_frame_tick with i_game_running high latches i_ball_x/i_ball_y (cycle T) and -> PROBE.
REQ-024 PROBE issues 5 queries on cycles T+1..T+5, o_query_valid high each: centre, (x-R,y), (x+R,y), (x,y-R), (x,y+R); R = BALL_RADIUS.
REQ-025 Probe coordinates saturate to [0, SCREEN_WIDTH-1] and [0, SCREEN_HEIGHT-1]; no wrap-around; arithmetic one bit wider than coordinate.
REQ-026 i_query_safe sampled T+2..T+6; sticky unsafe flag ORs any 0 result.
REQ-027 Decision at T+6 (last response): unsafe -> lose; else if latched y + R >= SCREEN_HEIGHT-1 -> win; else -> ARMED, no pulse.
REQ-028 On win/lose: o_round_ended high at T+7 for exactly one cycle, o_is_win set (1 win, 0 lose), state -> ENDED.
REQ-029 ENDED holds; ignores ticks, pause, i_level_rdy; o_is_win held.
REQ-030 i_frame_tick arriving during PROBE is dropped, not queued.
REQ-031 i_game_running falling during PROBE aborts probe: o_query_valid low next cycle, flag cleared, -> ARMED, no pulse.
REQ-032 i_regenerate_level in any state has priority: -> WAIT_RDY next cycle, o_is_win cleared, probe aborted, no pulse; simultaneous tick ignored.
REQ-033 i_level_rdy low in GRACE/ARMED/PROBE -> WAIT_RDY, no pulse.
REQ-034 Outputs registered; o_query_x/y hold last value when o_query_valid low.

Reset
REQ-035 arst_n low: state WAIT_RDY, o_round_ended 0, o_is_win 0, o_query_valid 0, o_query_x/y 0, o_busy 0, grace counter 0, unsafe flag 0.
REQ-036 Reset asserted mid-PROBE: all outputs to reset values immediately, no pulse after release.

Verification
REQ-037 Reset, i_level_rdy=1, 30 ticks running -> ARMED; tick at (200,300), all safe -> queries (200,300),(190,300),(210,300),(200,290),(200,310), no o_round_ended.
REQ-038 ARMED, ball (5,300), 4th response 0 -> second probe x=0 (saturated), o_round_ended pulse at T+7, o_is_win=0, state ENDED.
REQ-039 ARMED, ball (200,589), all safe -> o_round_ended at T+7, o_is_win=1; further ticks produce no pulse until i_regenerate_level.
REQ-040 GRACE with 10 frames left, pause 5 ticks, resume -> exactly 10 more running ticks to ARMED.
REQ-041 i_regenerate_level at T+4 with unsafe response at T+3 -> WAIT_RDY at T+5, no pulse, o_is_win 0.
REQ-042 Tick at T+3 during PROBE and i_game_running drop at T+3 in separate runs -> extra tick ignored; drop gives o_query_valid 0 at T+4, ARMED, no pulse.
